// File: rtl/ps2_keymatrix.sv
// PS/2 set-2 event stream to ZX Spectrum 8x5 key matrix, with composite PC keys
// mapped onto CAPS/SYMBOL SHIFT plus a base key, and the active-low ULA row read path.
module ps2_keymatrix (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       strb,
    input  logic       make,
    input  logic [7:0] code,
    input  logic [7:0] a,
    output logic [4:0] q,
    output logic       anykey
);

    logic [7:0][4:0] mtx_q, mtx_d;
    logic [2:0]      csf_q, csf_d;
    logic [2:0]      ssf_q, ssf_d;
    logic            lshift_q, lshift_d;
    logic            rshift_q, rshift_d;
    logic            lctrl_q, lctrl_d;
    logic            anykey_q, anykey_d;

    logic            caps, sym;
    logic [7:0][4:0] eff;
    logic [6:0]      dmap;

    // {hit, row[2:0], col[2:0]} for keys that map to exactly one matrix position
    function automatic logic [6:0] direct_map(input logic [7:0] c);
        case (c)
            8'h1A: direct_map = {1'b1, 3'd0, 3'd1}; // Z
            8'h22: direct_map = {1'b1, 3'd0, 3'd2}; // X
            8'h21: direct_map = {1'b1, 3'd0, 3'd3}; // C
            8'h2A: direct_map = {1'b1, 3'd0, 3'd4}; // V
            8'h1C: direct_map = {1'b1, 3'd1, 3'd0}; // A
            8'h1B: direct_map = {1'b1, 3'd1, 3'd1}; // S
            8'h23: direct_map = {1'b1, 3'd1, 3'd2}; // D
            8'h2B: direct_map = {1'b1, 3'd1, 3'd3}; // F
            8'h34: direct_map = {1'b1, 3'd1, 3'd4}; // G
            8'h15: direct_map = {1'b1, 3'd2, 3'd0}; // Q
            8'h1D: direct_map = {1'b1, 3'd2, 3'd1}; // W
            8'h24: direct_map = {1'b1, 3'd2, 3'd2}; // E
            8'h2D: direct_map = {1'b1, 3'd2, 3'd3}; // R
            8'h2C: direct_map = {1'b1, 3'd2, 3'd4}; // T
            8'h16: direct_map = {1'b1, 3'd3, 3'd0}; // 1
            8'h1E: direct_map = {1'b1, 3'd3, 3'd1}; // 2
            8'h26: direct_map = {1'b1, 3'd3, 3'd2}; // 3
            8'h25: direct_map = {1'b1, 3'd3, 3'd3}; // 4
            8'h2E: direct_map = {1'b1, 3'd3, 3'd4}; // 5
            8'h45: direct_map = {1'b1, 3'd4, 3'd0}; // 0
            8'h46: direct_map = {1'b1, 3'd4, 3'd1}; // 9
            8'h3E: direct_map = {1'b1, 3'd4, 3'd2}; // 8
            8'h3D: direct_map = {1'b1, 3'd4, 3'd3}; // 7
            8'h36: direct_map = {1'b1, 3'd4, 3'd4}; // 6
            8'h4D: direct_map = {1'b1, 3'd5, 3'd0}; // P
            8'h44: direct_map = {1'b1, 3'd5, 3'd1}; // O
            8'h43: direct_map = {1'b1, 3'd5, 3'd2}; // I
            8'h3C: direct_map = {1'b1, 3'd5, 3'd3}; // U
            8'h35: direct_map = {1'b1, 3'd5, 3'd4}; // Y
            8'h5A: direct_map = {1'b1, 3'd6, 3'd0}; // ENTER
            8'h4B: direct_map = {1'b1, 3'd6, 3'd1}; // L
            8'h42: direct_map = {1'b1, 3'd6, 3'd2}; // K
            8'h3B: direct_map = {1'b1, 3'd6, 3'd3}; // J
            8'h33: direct_map = {1'b1, 3'd6, 3'd4}; // H
            8'h29: direct_map = {1'b1, 3'd7, 3'd0}; // SPACE
            8'h3A: direct_map = {1'b1, 3'd7, 3'd2}; // M
            8'h31: direct_map = {1'b1, 3'd7, 3'd3}; // N
            8'h32: direct_map = {1'b1, 3'd7, 3'd4}; // B
            default: direct_map = 7'd0;
        endcase
    endfunction

    assign dmap = direct_map(code);

    always_comb begin
        mtx_d    = mtx_q;
        csf_d    = csf_q;
        ssf_d    = ssf_q;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        lctrl_d  = lctrl_q;
        if (ce && strb) begin
            case (code)
                8'hAA, 8'h00, 8'hFF: begin
                    mtx_d    = '1;
                    csf_d    = '0;
                    ssf_d    = '0;
                    lshift_d = 1'b0;
                    rshift_d = 1'b0;
                    lctrl_d  = 1'b0;
                end
                8'h12: lshift_d = ~make;
                8'h59: rshift_d = ~make;
                8'h14: lctrl_d  = ~make;
                // Left/right share one CAPS flag, up/down another, backspace the third
                8'h6B: begin csf_d[0] = ~make; mtx_d[3][4] = make; end
                8'h74: begin csf_d[0] = ~make; mtx_d[4][2] = make; end
                8'h72: begin csf_d[1] = ~make; mtx_d[4][4] = make; end
                8'h75: begin csf_d[1] = ~make; mtx_d[4][3] = make; end
                8'h66: begin csf_d[2] = ~make; mtx_d[4][0] = make; end
                8'h41: begin ssf_d[0] = ~make; mtx_d[7][3] = make; end
                8'h49: begin ssf_d[1] = ~make; mtx_d[7][2] = make; end
                8'h4E: begin ssf_d[2] = ~make; mtx_d[6][3] = make; end
                default: begin
                    if (dmap[6])
                        mtx_d[dmap[5:3]][dmap[2:0]] = make;
                end
            endcase
        end
    end

    // Shift positions are never written in mtx; they are derived from the held sources
    always_comb begin
        caps     = lshift_q | rshift_q | (|csf_q);
        sym      = lctrl_q | (|ssf_q);
        eff      = mtx_q;
        eff[0][0] = mtx_q[0][0] & ~caps;
        eff[7][1] = mtx_q[7][1] & ~sym;
        anykey_d = (eff != '1);
        q        = 5'h1F;
        for (int r = 0; r < 8; r++) begin
            if (!a[r])
                q = q & eff[r];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mtx_q    <= '1;
            csf_q    <= '0;
            ssf_q    <= '0;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            lctrl_q  <= 1'b0;
            anykey_q <= 1'b0;
        end else begin
            mtx_q    <= mtx_d;
            csf_q    <= csf_d;
            ssf_q    <= ssf_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            lctrl_q  <= lctrl_d;
            anykey_q <= anykey_d;
        end
    end

    assign anykey = anykey_q;

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Directed bench for ps2_keymatrix: stimulus pushes expected q/anykey into a queue,
// a negedge monitor pops and compares whenever a check is presented.
module tb_ps2_keymatrix;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b1;
    logic       strb = 1'b0;
    logic       make = 1'b1;
    logic [7:0] code = 8'h00;
    logic [7:0] a = 8'hFF;
    logic [4:0] q;
    logic       anykey;

    typedef struct {
        bit         is_any;
        logic [4:0] exp;
        string      name;
    } chk_t;

    chk_t chk_q[$];
    logic chk_v = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    ps2_keymatrix dut (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .strb  (strb),
        .make  (make),
        .code  (code),
        .a     (a),
        .q     (q),
        .anykey(anykey)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (chk_v) begin
            if (chk_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_underflow: check presented with no expected value");
            end else begin
                chk_t c;
                c = chk_q.pop_front();
                n_cmp++;
                if (c.is_any) begin
                    if (anykey !== c.exp[0]) begin
                        n_bad++;
                        $display("FAIL %s: anykey got %b want %b", c.name, anykey, c.exp[0]);
                    end
                end else if (q !== c.exp) begin
                    n_bad++;
                    $display("FAIL %s: a=%h q got %h want %h", c.name, a, q, c.exp);
                end
            end
        end
    end

    task automatic key(input logic mk, input logic [7:0] cd);
        @(posedge clock); #1;
        strb = 1'b1; make = mk; code = cd;
        @(posedge clock); #1;
        strb = 1'b0;
    endtask

    task automatic check_q(input logic [7:0] sel, input logic [4:0] exp, input string nm);
        chk_t c;
        c.is_any = 1'b0; c.exp = exp; c.name = nm;
        a = sel;
        chk_q.push_back(c);
        chk_v = 1'b1;
        @(posedge clock); #1;
        chk_v = 1'b0;
    endtask

    task automatic check_any(input logic exp, input string nm);
        chk_t c;
        c.is_any = 1'b1; c.exp = {4'b0, exp}; c.name = nm;
        chk_q.push_back(c);
        chk_v = 1'b1;
        @(posedge clock); #1;
        chk_v = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // 1: reset state
        check_q(8'hFE, 5'h1F, "rst_row0");
        check_q(8'h00, 5'h1F, "rst_all");
        check_any(1'b0, "rst_anykey");

        // 2: direct key A and anykey lag
        key(1'b0, 8'h1C);
        check_any(1'b0, "a_any_lag");
        check_q(8'hFD, 5'h1E, "a_press");
        check_any(1'b1, "a_any_set");
        key(1'b1, 8'h1C);
        check_q(8'hFD, 5'h1F, "a_release");
        check_any(1'b0, "a_any_clr");

        // 3: cursor left with overlapping LSHIFT
        key(1'b0, 8'h6B);
        check_q(8'hFE, 5'h1E, "left_caps");
        check_q(8'hF7, 5'h0F, "left_5");
        key(1'b0, 8'h12);
        key(1'b1, 8'h6B);
        check_q(8'hFE, 5'h1E, "caps_held_lshift");
        check_q(8'hF7, 5'h1F, "left_5_released");
        key(1'b1, 8'h12);
        check_q(8'hFE, 5'h1F, "caps_released");

        // 4: multi-row select
        key(1'b0, 8'h15);
        key(1'b0, 8'h16);
        check_q(8'hF6, 5'h1E, "rows_0_3");
        check_q(8'hFB, 5'h1E, "row2_q");
        check_q(8'hF7, 5'h1E, "row3_1");
        check_q(8'hFF, 5'h1F, "no_rows");
        key(1'b1, 8'h15);
        key(1'b1, 8'h16);
        check_q(8'h00, 5'h1F, "q1_released");

        // Composite comma with overlapping LCTRL
        key(1'b0, 8'h41);
        check_q(8'h7F, 5'h15, "comma_sym_n");
        key(1'b0, 8'h14);
        key(1'b1, 8'h41);
        check_q(8'h7F, 5'h1D, "sym_held_lctrl");
        key(1'b1, 8'h14);
        check_q(8'h7F, 5'h1F, "sym_released");

        // Typematic repeat then single release
        key(1'b0, 8'h1C);
        key(1'b0, 8'h1C);
        check_q(8'hFD, 5'h1E, "typematic_held");
        key(1'b1, 8'h1C);
        check_q(8'hFD, 5'h1F, "typematic_release");

        // 5: self-test code clears everything
        key(1'b0, 8'h1C);
        key(1'b0, 8'h29);
        key(1'b0, 8'h5A);
        key(1'b0, 8'h66);
        check_q(8'h7F, 5'h1E, "space_press");
        check_q(8'hEF, 5'h1E, "bksp_0");
        key(1'b0, 8'hAA);
        check_q(8'h00, 5'h1F, "aa_clear_all");
        check_q(8'hFE, 5'h1F, "aa_clear_caps");
        check_any(1'b0, "aa_any");

        // Reset coincident with a strb press
        key(1'b0, 8'h1C);
        @(posedge clock); #1;
        reset = 1'b1; strb = 1'b1; make = 1'b0; code = 8'h22;
        @(posedge clock); #1;
        reset = 1'b0; strb = 1'b0;
        check_q(8'h00, 5'h1F, "reset_drops_press");

        // 6: ce=0 blocks events, unmapped code ignored
        @(posedge clock); #1;
        ce = 1'b0; strb = 1'b1; make = 1'b0; code = 8'h1C;
        @(posedge clock); #1;
        strb = 1'b0; ce = 1'b1;
        check_q(8'hFD, 5'h1F, "ce_low_ignored");
        key(1'b0, 8'h07);
        check_q(8'h00, 5'h1F, "unmapped_ignored");
        check_any(1'b0, "unmapped_any");

        begin
            int t = 0;
            while (chk_q.size() != 0 && t < 100) begin
                @(posedge clock);
                t++;
            end
            if (chk_q.size() != 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_drain: %0d left want 0", chk_q.size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
